// File: rtl/axi4_dma_read_stream.sv
// AXI4 read-master DMA: fetches a contiguous block of beats in 4 KB-safe INCR bursts
// and forwards the read data unbuffered as an AXI4-Stream.
module axi4_dma_read_stream #(
    parameter int                      AXI_ID_WIDTH    = 6,
    parameter int                      AXI_ADDR_WIDTH  = 49,
    parameter int                      AXI_DATA_SIZE   = 4,
    parameter int                      AXI_DATA_WIDTH  = 8 << AXI_DATA_SIZE,
    parameter int                      AXI_LEN_WIDTH   = 8,
    parameter int                      LEN_WIDTH       = 32,
    parameter int                      MAX_BURST       = 16,
    parameter int                      MAX_OUTSTANDING = 4,
    parameter logic [AXI_ID_WIDTH-1:0] ARID            = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [AXI_ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]      start_len,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [AXI_ID_WIDTH-1:0]   m_axi4_arid,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi4_araddr,
    output logic [AXI_LEN_WIDTH-1:0]  m_axi4_arlen,
    output logic [2:0]                m_axi4_arsize,
    output logic [1:0]                m_axi4_arburst,
    output logic                      m_axi4_arlock,
    output logic [3:0]                m_axi4_arcache,
    output logic [2:0]                m_axi4_arprot,
    output logic [3:0]                m_axi4_arqos,
    output logic                      m_axi4_aruser,
    output logic                      m_axi4_arvalid,
    input  logic                      m_axi4_arready,
    input  logic [AXI_ID_WIDTH-1:0]   m_axi4_rid,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi4_rdata,
    input  logic [1:0]                m_axi4_rresp,
    input  logic                      m_axi4_rlast,
    input  logic                      m_axi4_rvalid,
    output logic                      m_axi4_rready,
    output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready
);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                    state;
    logic [AXI_ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]      ar_remaining;
    logic [LEN_WIDTH-1:0]      rx_remaining;
    logic [LEN_WIDTH-1:0]      burst_beats;
    logic [LEN_WIDTH-1:0]      next_beats;
    logic [OUT_W-1:0]          outstanding;
    logic                      ar_fire;
    logic                      r_fire;
    logic                      r_last_fire;
    logic                      unused_sig;

    // Largest burst that fits the remaining length, the burst cap and the current 4 KB page.
    function automatic logic [LEN_WIDTH-1:0] burst_len(input logic [LEN_WIDTH-1:0] remaining,
                                                       input logic [11:0]          page_off);
        logic [LEN_WIDTH-1:0] page_beats;
        logic [LEN_WIDTH-1:0] beats;
        page_beats = LEN_WIDTH'((13'h1000 - {1'b0, page_off}) >> AXI_DATA_SIZE);
        beats      = remaining;
        if (beats > LEN_WIDTH'(MAX_BURST)) beats = LEN_WIDTH'(MAX_BURST);
        if (beats > page_beats) beats = page_beats;
        return beats;
    endfunction

    assign next_beats  = burst_len(ar_remaining, cur_addr[11:0]);
    assign ar_fire     = m_axi4_arvalid & m_axi4_arready;
    assign r_fire      = m_axi4_rvalid & m_axi4_rready;
    assign r_last_fire = r_fire & m_axi4_rlast;
    assign unused_sig  = ^{m_axi4_rid, start_addr[AXI_DATA_SIZE-1:0]};

    assign m_axi4_arid    = ARID;
    assign m_axi4_arsize  = 3'(AXI_DATA_SIZE);
    assign m_axi4_arburst = 2'b01;
    assign m_axi4_arlock  = 1'b0;
    assign m_axi4_arcache = 4'b0011;
    assign m_axi4_arprot  = 3'b000;
    assign m_axi4_arqos   = 4'b0000;
    assign m_axi4_aruser  = 1'b0;

    // Stream backpressure stalls the R channel directly; nothing is buffered.
    assign m_axis_tdata  = m_axi4_rdata;
    assign m_axis_tvalid = m_axi4_rvalid & busy;
    assign m_axi4_rready = m_axis_tready & busy;
    assign m_axis_tlast  = (rx_remaining == LEN_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            m_axi4_arvalid <= 1'b0;
            m_axi4_araddr  <= '0;
            m_axi4_arlen   <= '0;
            cur_addr       <= '0;
            ar_remaining   <= '0;
            rx_remaining   <= '0;
            burst_beats    <= '0;
            outstanding    <= '0;
        end else begin
            done <= 1'b0;
            if (r_fire) begin
                rx_remaining <= rx_remaining - LEN_WIDTH'(1);
                if (m_axi4_rresp != 2'b00) err <= 1'b1;
            end
            if (ar_fire && !r_last_fire) outstanding <= outstanding + OUT_W'(1);
            else if (!ar_fire && r_last_fire) outstanding <= outstanding - OUT_W'(1);

            case (state)
                IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        if (start_len != '0) begin
                            cur_addr     <= {start_addr[AXI_ADDR_WIDTH-1:AXI_DATA_SIZE],
                                             {AXI_DATA_SIZE{1'b0}}};
                            ar_remaining <= start_len;
                            rx_remaining <= start_len;
                            busy         <= 1'b1;
                            state        <= ISSUE;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // arvalid drops after every handshake, so at most one AR per two cycles.
                    if (ar_fire) begin
                        cur_addr       <= cur_addr + (AXI_ADDR_WIDTH'(burst_beats) << AXI_DATA_SIZE);
                        ar_remaining   <= ar_remaining - burst_beats;
                        m_axi4_arvalid <= 1'b0;
                        if (ar_remaining == burst_beats) state <= WAIT;
                    end else if (!m_axi4_arvalid && outstanding < OUT_W'(MAX_OUTSTANDING) &&
                                 ar_remaining != '0) begin
                        m_axi4_arvalid <= 1'b1;
                        m_axi4_araddr  <= cur_addr;
                        m_axi4_arlen   <= AXI_LEN_WIDTH'(next_beats - LEN_WIDTH'(1));
                        burst_beats    <= next_beats;
                    end
                end
                WAIT: begin
                    if (rx_remaining == '0 && outstanding == '0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
